// File: rtl/instruction_pkg.sv
// Shared instruction-level types for the fetch/decode boundary.
//   opcode_t       - RV32/RV64 base opcodes recognised by the front end
//   instruction_t  - 32-bit instruction split into its standard fields
//   imm_format_t   - immediate format tag emitted with each instruction
//   skid_state_t   - occupancy of the two-entry skid buffer
package instruction_pkg;

    typedef enum logic [6:0] {
        LoadType   = 7'b0000011,
        Fence      = 7'b0001111,
        AluIType   = 7'b0010011,
        Auipc      = 7'b0010111,
        AluIWType  = 7'b0011011,
        SType      = 7'b0100011,
        AluRType   = 7'b0110011,
        Lui        = 7'b0110111,
        AluRWType  = 7'b0111011,
        BType      = 7'b1100011,
        Jalr       = 7'b1100111,
        Jal        = 7'b1101111,
        SystemType = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        opcode_t    opcode;
    } instruction_t;

    // ImmNone must stay encoded as zero: reset clears stored entries with '0.
    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5,
        ImmZ    = 3'd6
    } imm_format_t;

    localparam logic [2:0] SllFunct3       = 3'b001;
    localparam logic [2:0] SrlSraFunct3    = 3'b101;
    // funct3 bit that selects the immediate (zimm) flavour of CSR ops
    localparam int         CsrImmFunct3Bit = 2;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/immediate_extender_stage_imm_decode.sv
// imm_decode: combinational immediate extractor.
//   instruction   in   raw instruction
//   immediate     out  immediate extended to N bits
//   fmt           out  format tag
//   illegal_shamt out  shift amount too wide for the datapath
module imm_decode
    import instruction_pkg::*;
#(
    parameter int N       = 64,
    parameter bit ZIMM_EN = 1'b1
) (
    input  instruction_t   instruction,
    output logic [N-1:0]   immediate,
    output imm_format_t    fmt,
    output logic           illegal_shamt
);

    logic [31:0] raw;
    logic [31:0] imm32;
    logic        is_shift;

    assign raw = instruction;

    always_comb begin
        fmt = ImmNone;
        case (instruction.opcode)
            AluIType, AluIWType, LoadType, Jalr: fmt = ImmI;
            SType:                               fmt = ImmS;
            BType:                               fmt = ImmB;
            Lui, Auipc:                          fmt = ImmU;
            Jal:                                 fmt = ImmJ;
            SystemType: begin
                if (ZIMM_EN && instruction.funct3[CsrImmFunct3Bit])
                    fmt = ImmZ;
            end
            default:                             fmt = ImmNone;
        endcase
    end

    // Every format is first built as a 32-bit value sign-extended from bit 31;
    // zimm has bit 31 clear, so the common widening below zero-extends it.
    always_comb begin
        imm32 = '0;
        case (fmt)
            ImmI: imm32 = {{20{raw[31]}}, raw[31:20]};
            ImmS: imm32 = {{20{raw[31]}}, raw[31:25], raw[11:7]};
            ImmB: imm32 = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
            ImmU: imm32 = {raw[31:12], 12'b0};
            ImmJ: imm32 = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
            ImmZ: imm32 = {27'b0, raw[19:15]};
            default: imm32 = '0;
        endcase
    end

    generate
        if (N > 32) begin : g_wide
            assign immediate = {{(N-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign immediate = imm32[N-1:0];
        end
    endgenerate

    // inst[25] is shamt[5]: only legal for 64-bit non-word shifts.
    assign is_shift = (instruction.funct3 == SllFunct3) ||
                      (instruction.funct3 == SrlSraFunct3);

    always_comb begin
        illegal_shamt = 1'b0;
        if (is_shift && raw[25]) begin
            if (instruction.opcode == AluIWType)
                illegal_shamt = 1'b1;
            else if (instruction.opcode == AluIType && N == 32)
                illegal_shamt = 1'b1;
        end
    end

endmodule

// File: rtl/immediate_extender_stage.sv
// immediate_extender_stage: registered immediate extender between fetch and
// decode, with a two-entry skid buffer so in_ready never depends on out_ready.
//   clock, reset_n        clock and synchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is a flop)
//   in_instruction        incoming instruction
//   out_valid/out_ready   downstream handshake
//   out_instruction       accepted instruction, passed through
//   out_immediate         N-bit extended immediate
//   out_format            immediate format tag
//   out_illegal_shamt     shift amount out of range for N
module immediate_extender_stage
    import instruction_pkg::*;
#(
    parameter int N       = 64,
    parameter bit ZIMM_EN = 1'b1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  instruction_t   in_instruction,
    output logic           out_valid,
    input  logic           out_ready,
    output instruction_t   out_instruction,
    output logic [N-1:0]   out_immediate,
    output imm_format_t    out_format,
    output logic           out_illegal_shamt
);

    typedef struct packed {
        instruction_t   instruction;
        logic [N-1:0]   immediate;
        imm_format_t    fmt;
        logic           illegal_shamt;
    } entry_t;

    entry_t       dec_entry;
    entry_t       main_q;
    entry_t       skid_q;
    skid_state_t  state_q;
    skid_state_t  state_d;
    logic         ready_q;
    logic         in_xfer;
    logic         out_xfer;
    logic         load_main_new;
    logic         load_main_skid;
    logic         load_skid;

    imm_decode #(
        .N       (N),
        .ZIMM_EN (ZIMM_EN)
    ) u_imm_decode (
        .instruction   (in_instruction),
        .immediate     (dec_entry.immediate),
        .fmt           (dec_entry.fmt),
        .illegal_shamt (dec_entry.illegal_shamt)
    );

    assign dec_entry.instruction = in_instruction;

    assign in_xfer  = in_valid & ready_q;
    assign out_xfer = (state_q != StEmpty) & out_ready;

    // State register; in_ready is registered from the next state so it is
    // a pure flop output.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != StFull);
        end
    end

    // Next state and datapath load enables.
    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d       = StOne;
                    load_main_new = 1'b1;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    load_main_new = 1'b1;
                end else if (in_xfer) begin
                    state_d   = StFull;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // ready_q is low here, so no input can arrive.
                if (out_xfer) begin
                    state_d        = StOne;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_new)
                main_q <= dec_entry;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= dec_entry;
        end
    end

    // Outputs: the head of the queue always lives in main_q.
    always_comb begin
        out_valid         = (state_q != StEmpty);
        in_ready          = ready_q;
        out_instruction   = main_q.instruction;
        out_immediate     = main_q.immediate;
        out_format        = main_q.fmt;
        out_illegal_shamt = main_q.illegal_shamt;
    end

endmodule

// File: tb/tb_immediate_extender_stage.sv
module tb_immediate_extender_stage;
  import instruction_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;

  logic         rdy64, vld64, ill64, rdy32, vld32, ill32;
  instruction_t oi64, oi32;
  logic [63:0]  imm64;
  logic [31:0]  imm32;
  imm_format_t  f64, f32;

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];

  always #5 clock = ~clock;

  immediate_extender_stage #(.N(64), .ZIMM_EN(1'b1)) dut64 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_instruction(in_inst), .out_valid(vld64), .out_ready(out_ready),
    .out_instruction(oi64), .out_immediate(imm64), .out_format(f64),
    .out_illegal_shamt(ill64));

  immediate_extender_stage #(.N(32), .ZIMM_EN(1'b0)) dut32 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_instruction(in_inst), .out_valid(vld32), .out_ready(out_ready),
    .out_instruction(oi32), .out_immediate(imm32), .out_format(f32),
    .out_illegal_shamt(ill32));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode straight from the ISA immediate definitions, built
  // with integer arithmetic on the field values.
  function automatic void ref_dec(input logic [31:0] i, input int n, input bit zimm,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output bit ill);
    longint v = 0;
    bit shift = (i[14:12] == 3'd1) || (i[14:12] == 3'd5);
    fmt = 3'd0;
    ill = 1'b0;
    case (i[6:0])
      7'h13, 7'h1B, 7'h03, 7'h67: begin
        fmt = 3'd1;
        v = longint'(i[31:20]);
        if (i[31]) v = v - 4096;
      end
      7'h23: begin
        fmt = 3'd2;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (i[31]) v = v - 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (i[31]) v = v - 4096;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v = longint'(i[31:12]) * 4096;
        if (i[31]) v = v - 64'h1_0000_0000;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (i[31]) v = v - (64'd1 << 20);
      end
      7'h73: begin
        if (zimm && i[14]) begin
          fmt = 3'd6;
          v = longint'(i[19:15]);
        end
      end
      default: v = 0;
    endcase
    if (shift && i[25] && ((i[6:0] == 7'h13 && n == 32) || i[6:0] == 7'h1B)) ill = 1'b1;
    imm = (n == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  task automatic check_head();
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    bit          e_ill;
    ref_dec(q[0], 64, 1'b1, e_imm, e_fmt, e_ill);
    chk("inst64", oi64, q[0]);
    chk("imm64", imm64, e_imm);
    chk("fmt64", f64, e_fmt);
    chk("ill64", ill64, e_ill);
    ref_dec(q[0], 32, 1'b0, e_imm, e_fmt, e_ill);
    chk("inst32", oi32, q[0]);
    chk("imm32", {32'b0, imm32}, e_imm);
    chk("fmt32", f32, e_fmt);
    chk("ill32", ill32, e_ill);
  endtask

  // One cycle: check outputs against the queue model, drive inputs, advance
  // to the next falling edge and apply the transfers the model predicts.
  task automatic step(input bit v, input logic [31:0] inst, input bit rdy, input bit rst_n = 1'b1);
    bit mready = (q.size() < 2);
    bit mvalid = (q.size() > 0);
    chk("in_ready64", rdy64, mready);
    chk("in_ready32", rdy32, mready);
    chk("out_valid64", vld64, mvalid);
    chk("out_valid32", vld32, mvalid);
    if (mvalid) check_head();
    in_valid = v;
    in_inst = inst;
    out_ready = rdy;
    reset_n = rst_n;
    @(posedge clock);
    if (!rst_n) q.delete();
    else begin
      if (mvalid && rdy) void'(q.pop_front());
      if (v && mready) q.push_back(inst);
    end
    @(negedge clock);
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm64;
    logic [2:0]  f64;
    bit          ill64;
    logic [31:0] imm32;
    logic [2:0]  f32;
    bit          ill32;
  } vec_t;

  vec_t tbl[10];
  logic [6:0] ops[14];

  initial begin
    logic [31:0] r;
    tbl[0] = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0};
    tbl[1] = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0};
    tbl[2] = '{32'h3002D073, 64'h5,                3'd6, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[3] = '{32'h02101093, 64'h21,               3'd1, 1'b0, 32'h21,       3'd1, 1'b1};
    tbl[4] = '{32'hFE20AE23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 32'hFFFFFFFC, 3'd2, 1'b0};
    tbl[5] = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0, 32'hFFFFFFF8, 3'd3, 1'b0};
    tbl[6] = '{32'h0010006F, 64'h800,              3'd5, 1'b0, 32'h800,      3'd5, 1'b0};
    tbl[7] = '{32'h003100B3, 64'h0,                3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[8] = '{32'h0200D09B, 64'h20,               3'd1, 1'b1, 32'h20,       3'd1, 1'b1};
    tbl[9] = '{32'h4280D093, 64'h428,              3'd1, 1'b0, 32'h428,      3'd1, 1'b1};
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37,
            7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};

    // Reset with in_valid asserted: it must be ignored.
    in_valid = 1'b1;
    in_inst = 32'hFFF00093;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", vld64, 1'b0);
    chk("rst_in_ready", rdy64, 1'b1);
    chk("rst_inst", oi64, 32'h0);
    chk("rst_imm", imm64, 64'h0);
    chk("rst_fmt", f64, ImmNone);
    chk("rst_ill", ill64, 1'b0);
    in_valid = 1'b0;
    reset_n = 1'b1;

    // Directed vectors, one per cycle with out_ready high.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, tbl[k].inst, 1'b1);
      chk("tbl_vld64", vld64, 1'b1);
      chk("tbl_imm64", imm64, tbl[k].imm64);
      chk("tbl_fmt64", f64, tbl[k].f64);
      chk("tbl_ill64", ill64, tbl[k].ill64);
      chk("tbl_imm32", {32'b0, imm32}, {32'b0, tbl[k].imm32});
      chk("tbl_fmt32", f32, tbl[k].f32);
      chk("tbl_ill32", ill32, tbl[k].ill32);
    end
    step(1'b0, 32'h0, 1'b1);

    // Backpressure: A, B fill the buffer, C waits upstream.
    step(1'b1, tbl[4].inst, 1'b0);
    step(1'b1, tbl[5].inst, 1'b0);
    chk("bp_full_ready", rdy64, 1'b0);
    step(1'b1, tbl[6].inst, 1'b0);
    step(1'b1, tbl[6].inst, 1'b0);
    chk("bp_stable_a", oi64, tbl[4].inst);
    step(1'b1, tbl[6].inst, 1'b1);
    chk("bp_b_next", oi64, tbl[5].inst);
    chk("bp_ready_back", rdy64, 1'b1);
    step(1'b1, tbl[6].inst, 1'b1);
    chk("bp_c_next", oi64, tbl[6].inst);
    step(1'b0, 32'h0, 1'b1);
    chk("bp_drained", vld64, 1'b0);

    // Reset while FULL, then normal flow resumes.
    step(1'b1, tbl[0].inst, 1'b0);
    step(1'b1, tbl[1].inst, 1'b0);
    chk("rf_full_ready", rdy64, 1'b0);
    step(1'b1, tbl[2].inst, 1'b0, 1'b0);
    chk("rf_out_valid", vld64, 1'b0);
    chk("rf_in_ready", rdy64, 1'b1);
    chk("rf_fmt", f64, ImmNone);
    step(1'b1, tbl[3].inst, 1'b1);
    chk("rf_resume_valid", vld64, 1'b1);
    chk("rf_resume_inst", oi64, tbl[3].inst);

    // Random traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      r = $urandom();
      step($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 13)]},
           $urandom_range(0, 2) != 0);
    end
    repeat (3) step(1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/immediate_extender_stage.md
Name: immediate_extender_stage

Overview:
- Registered, flow-controlled successor to the combinational immediate extender.
- Sits between fetch and decode.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and emits the instruction, its sign/zero-extended immediate, a format tag and legality flags one cycle later.
- Parametrised for RV32/RV64 (N) and adds formats the old block lacks: CSR zimm and shamt legality.

Parameters:
- N, 64, datapath width; legal values 32 or 64.
- ZIMM_EN, 1, 1 decodes the CSR immediate (SystemType with funct3[2]=1) as format ImmZ; 0 maps it to ImmNone.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream offers an instruction.
- in_ready  output  1  stage can accept; registered.
- in_instruction  input  32  instruction_t.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_instruction  output  32  passthrough of the accepted instruction.
- out_immediate  output  N  extended immediate.
- out_format  output  3  imm_format_t.
- out_illegal_shamt  output  1  shift immediate out of range for N.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clock, reset_n).
- Two-entry skid buffer: main register plus skid register. States:
  - EMPTY: nothing held.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- in_ready = (state != FULL); it is registered, not combinationally dependent on out_ready.
- Transitions:
  - EMPTY: input transfer -> ONE.
  - ONE: input without output -> FULL. Output without input -> EMPTY. Both -> stays ONE with the new entry. Neither -> holds.
  - FULL: output transfer -> skid moves to main, ONE. Input is impossible in FULL.
- Latency: an instruction accepted at edge k is on the outputs with out_valid=1 after edge k (visible in cycle k+1). Throughput is 1 per cycle when out_ready=1.
- Outputs are stable while out_valid & !out_ready.
- Order is preserved; no entry is lost or duplicated.
- Immediate is computed before registering; both entries store the full decoded result.
- Format rules (instruction bits; sign-extend to N unless stated):
  - ImmI: AluIType, AluIWType, LoadType, Jalr -> inst[31:20].
  - ImmS: SType -> {inst[31:25], inst[11:7]}.
  - ImmB: BType -> {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - ImmU: Lui, Auipc -> {inst[31:12], 12'b0}, sign-extended from bit 31.
  - ImmJ: Jal -> {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - ImmZ: SystemType with funct3[2]=1 and ZIMM_EN=1 -> zero-extended inst[19:15].
  - ImmNone: all other opcodes (AluRType, AluRWType, Fence, other SystemType, unknown) -> immediate 0.
- out_illegal_shamt = 1 when either holds:
  - AluIType shift (funct3 001 or 101) with N=32 and inst[25]=1.
  - AluIWType shift with inst[25]=1.
  - Otherwise 0. The flag does not block the handshake.
- Reset (reset_n=0 at an edge, any state, including mid-backpressure):
  - state -> EMPTY; both entries discarded.
  - out_valid=0, in_ready=1, out_instruction=0, out_immediate=0, out_format=ImmNone, out_illegal_shamt=0.
  - in_valid is ignored during the reset cycle.
- out_valid=0 implies the data outputs hold their last values (don't care to the consumer). The bench checks them only when out_valid=1.

Decomposition:
- Add to instruction_pkg:
  - imm_format_t enum: ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ, ImmZ.
  - Constants for funct3 shift codes (SllFunct3=3'b001, SrlSraFunct3=3'b101) and the CSR immediate funct3 bit index.
- Reuse existing opcode_t and instruction_t.
- One sub-module: imm_decode #(N, ZIMM_EN), purely combinational (instruction -> immediate, format, illegal_shamt), instantiated once on the input side.
- The skid buffer and FSM stay in the top.

Test Plan:
1. N=64, addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_immediate=0xFFFFFFFFFFFFFFFF, out_format=ImmI, out_illegal_shamt=0.
2. lui x1,0x80000 (0x800000B7) -> N=64: 0xFFFFFFFF80000000, ImmU. N=32: 0x80000000.
3. csrrwi x0,0x300,5 (0x3002D073): ZIMM_EN=1 -> immediate 5, ImmZ. ZIMM_EN=0 -> immediate 0, ImmNone.
4. slli x1,x0,33 (0x02101093) -> N=32: illegal_shamt=1, immediate 0x00000021. N=64: illegal_shamt=0.
5. Backpressure: out_ready=0, send A, B, C back-to-back -> in_ready=0 after B is accepted, C is held upstream. Raise out_ready -> A, B, C emerge in order on consecutive cycles, in_ready returns to 1.
6. Reset in FULL: reset_n=0 for one edge -> next cycle out_valid=0, in_ready=1, out_format=ImmNone; the subsequent instruction flows normally with 1-cycle latency.
